// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the skid-buffered pipeline stage register.
package pipe_pkg;

    // Occupancy-encoded state; the unused code 2'd3 is treated as illegal
    // and recovers to ST_EMPTY.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam int CNT_W_DEFAULT = 32;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Ready/valid handshake bundle for one pipeline stage: upstream side and
// downstream side of the stage register.
interface pipe_skid_reg_if #(
    parameter int WIDTH = 256
);
    logic               in_valid;
    logic               in_ready;
    logic [0:WIDTH-1]   in;
    logic               out_valid;
    logic               out_ready;
    logic [0:WIDTH-1]   out;

    // View of the stage register itself.
    modport slave (
        input  in_valid, in, out_ready,
        output in_ready, out_valid, out
    );

    // View of the environment driving upstream and consuming downstream.
    modport master (
        output in_valid, in, out_ready,
        input  in_ready, out_valid, out
    );
endinterface

// File: rtl/pipe_skid_reg_data_reg.sv
// Payload register with synchronous clear to the NOP pattern.
module pipe_data_reg #(
    parameter int               WIDTH     = 256,
    parameter logic [0:WIDTH-1] NOP_VALUE = '0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              clr,
    input  logic              load,
    input  logic [0:WIDTH-1]  d,
    output logic [0:WIDTH-1]  q
);

    // Clear (reset or squash) wins over load.
    always_ff @(posedge Clk) begin
        if (Rst || clr) begin
            q <= NOP_VALUE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with ready/valid handshake, 2-entry skid buffer,
// flush-to-NOP and a saturating stall counter. in_ready/out_valid are
// decoded from registered state only, so no combinational ready path exists.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 256,
    parameter logic [0:WIDTH-1] NOP_VALUE = '0,
    parameter int               CNT_W     = CNT_W_DEFAULT
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              flush,
    pipe_skid_reg_if.slave    bus,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cycles
);

    state_t            state;
    logic              in_ready_int;
    logic              out_valid_int;
    logic              accept;
    logic              emit;

    logic              main_clr;
    logic              main_load;
    logic [0:WIDTH-1]  main_d;
    logic [0:WIDTH-1]  main_q;
    logic              skid_clr;
    logic              skid_load;
    logic [0:WIDTH-1]  skid_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign in_ready_int  = (state != ST_FULL);
    assign out_valid_int = (state != ST_EMPTY);
    assign accept        = bus.in_valid & in_ready_int & ~flush;
    assign emit          = out_valid_int & bus.out_ready & ~flush;

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_int;
    assign bus.out       = main_q;

    // Occupancy mirrors the state; an illegal code reports empty.
    always_comb begin
        occupancy = 2'd0;
        case (state)
            ST_ONE:  occupancy = 2'd1;
            ST_FULL: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // Data-path steering: which register loads, clears, and what feeds main.
    always_comb begin
        main_clr  = flush;
        main_load = 1'b0;
        main_d    = bus.in;
        skid_clr  = flush;
        skid_load = 1'b0;
        case (state)
            ST_EMPTY: begin
                main_load = accept;
            end
            ST_ONE: begin
                main_load = accept & emit;
                main_clr  = flush | (emit & ~accept);
                skid_load = accept & ~emit;
            end
            ST_FULL: begin
                main_d    = skid_q;
                main_load = emit;
                skid_clr  = flush | emit;
            end
            default: begin
                main_clr  = 1'b1;
                skid_clr  = 1'b1;
            end
        endcase
    end

    // Occupancy state machine: reset, then flush, then handshake transitions.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= ST_EMPTY;
        end else if (flush) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (accept) state <= ST_ONE;
                ST_ONE: begin
                    if (accept && !emit)      state <= ST_FULL;
                    else if (emit && !accept) state <= ST_EMPTY;
                end
                ST_FULL:  if (emit) state <= ST_ONE;
                default:  state <= ST_EMPTY;
            endcase
        end
    end

    // Stall counter: counts stalled cycles including flush cycles, only Rst clears.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            stall_cycles <= '0;
        end else if (out_valid_int && !bus.out_ready) begin
            stall_cycles <= sat_inc(stall_cycles);
        end
    end

    pipe_data_reg #(
        .WIDTH     (WIDTH),
        .NOP_VALUE (NOP_VALUE)
    ) u_main (
        .Clk  (Clk),
        .Rst  (Rst),
        .clr  (main_clr),
        .load (main_load),
        .d    (main_d),
        .q    (main_q)
    );

    pipe_data_reg #(
        .WIDTH     (WIDTH),
        .NOP_VALUE (NOP_VALUE)
    ) u_skid (
        .Clk  (Clk),
        .Rst  (Rst),
        .clr  (skid_clr),
        .load (skid_load),
        .d    (bus.in),
        .q    (skid_q)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: a queue-based reference model pushes
// accepted payloads, a negedge monitor pops them as the DUT emits.
module tb_pipe_skid_reg;
    import pipe_pkg::*;

    localparam int          W   = 32;
    localparam logic [31:0] NOP = 32'hDEAD_BEEF;

    logic        Clk;
    logic        Rst;
    logic        flush;
    logic [1:0]  occupancy;
    logic [31:0] stall_cycles;

    pipe_skid_reg_if #(.WIDTH(W)) bus ();

    pipe_skid_reg #(.WIDTH(W), .NOP_VALUE(NOP), .CNT_W(32)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .flush        (flush),
        .bus          (bus),
        .occupancy    (occupancy),
        .stall_cycles (stall_cycles)
    );

    // Small instance for counter saturation.
    logic        rst4;
    logic        fl4;
    logic [1:0]  occ4;
    logic [3:0]  stall4;

    pipe_skid_reg_if #(.WIDTH(8)) b4 ();

    pipe_skid_reg #(.WIDTH(8), .NOP_VALUE(8'h00), .CNT_W(4)) dut4 (
        .Clk          (Clk),
        .Rst          (rst4),
        .flush        (fl4),
        .bus          (b4),
        .occupancy    (occ4),
        .stall_cycles (stall4)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    int          mocc   = 0;
    logic [31:0] mstall = '0;
    logic        acc_last = 1'b0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: stage holds up to two payloads in arrival order.
    always @(posedge Clk) begin
        acc_last = 1'b0;
        if (Rst) begin
            mocc   = 0;
            mstall = '0;
            exp_q.delete();
        end else begin
            if (mocc > 0 && !bus.out_ready && mstall != 32'hFFFF_FFFF)
                mstall = mstall + 1;
            if (flush) begin
                exp_q.delete();
                mocc = 0;
            end else begin
                int em, ac;
                em = (mocc > 0 && bus.out_ready) ? 1 : 0;
                ac = (bus.in_valid && mocc < 2) ? 1 : 0;
                if (ac == 1) exp_q.push_back(bus.in);
                acc_last = (ac == 1);
                mocc = mocc - em + ac;
            end
        end
    end

    // Monitor: compares the DUT against the model mid-cycle, pops on emit.
    initial begin
        @(posedge Clk);
        forever begin
            @(negedge Clk);
            chk("out_valid", bus.out_valid, (mocc > 0));
            chk("in_ready", bus.in_ready, (mocc < 2));
            chk("occupancy", occupancy, mocc);
            chk("stall_cycles", stall_cycles, mstall);
            if (!bus.out_valid) begin
                chk("out_nop", bus.out, NOP);
            end else if (exp_q.size() == 0) begin
                chk("out_extra", exp_q.size(), 1);
            end else begin
                chk("out_data", bus.out, exp_q[0]);
                if (bus.out_ready && !flush && !Rst) void'(exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
        bus.in_valid  = v;
        bus.in        = d;
        bus.out_ready = r;
        flush         = f;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [31:0] cur;
        logic        v, r, f, pend, lastf;

        Rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in = '0; bus.out_ready = 1'b0;
        rst4 = 1'b1; fl4 = 1'b0;
        b4.in_valid = 1'b0; b4.in = '0; b4.out_ready = 1'b0;

        repeat (2) @(posedge Clk);
        #1;
        chk("rst_out", bus.out, NOP);
        chk("rst_occ", occupancy, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_stall", stall_cycles, 0);
        Rst = 1'b0;

        // Stream with downstream always ready.
        drive(1'b1, 32'h1, 1'b1, 1'b0);
        chk("stream_first", bus.out, 32'h1);
        drive(1'b1, 32'h2, 1'b1, 1'b0);
        chk("stream_second", bus.out, 32'h2);
        drive(1'b1, 32'h3, 1'b1, 1'b0);
        chk("stream_third", bus.out, 32'h3);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // Back-pressure fills the skid entry, then drains in order.
        drive(1'b1, 32'hA, 1'b0, 1'b0);
        drive(1'b1, 32'hB, 1'b0, 1'b0);
        chk("bp_occ_full", occupancy, 2);
        chk("bp_in_ready_low", bus.in_ready, 0);
        drive(1'b1, 32'hC, 1'b0, 1'b0);
        drive(1'b1, 32'hC, 1'b0, 1'b0);
        drive(1'b1, 32'hC, 1'b1, 1'b0);
        drive(1'b1, 32'hC, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush while full; 0xD must never surface.
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        drive(1'b1, 32'h11, 1'b0, 1'b0);
        drive(1'b1, 32'hD, 1'b0, 1'b1);
        chk("flush_out_valid", bus.out_valid, 0);
        chk("flush_in_ready", bus.in_ready, 1);
        chk("flush_out", bus.out, NOP);
        chk("flush_occ", occupancy, 0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // 100 cycles of simultaneous accept and emit.
        for (int i = 0; i < 100; i++) drive(1'b1, 32'h100 + i, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // Random traffic with occasional flush; upstream holds unaccepted data.
        pend = 1'b0; lastf = 1'b0; cur = '0; v = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (!(pend && !acc_last && !lastf)) begin
                v   = ($urandom_range(0, 3) != 0);
                cur = $urandom;
            end
            r = ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 99) < 5);
            drive(v, cur, r, f);
            pend  = v;
            lastf = f;
        end
        repeat (3) drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drain_empty", exp_q.size(), 0);

        // Saturation on the 4-bit counter.
        @(posedge Clk); #1;
        rst4 = 1'b0;
        b4.in_valid = 1'b1; b4.in = 8'h5A; b4.out_ready = 1'b0;
        @(posedge Clk); #1;
        b4.in_valid = 1'b0;
        repeat (10) @(posedge Clk);
        #1;
        chk("sat_stall10", stall4, 10);
        chk("sat_out", b4.out, 8'h5A);
        repeat (10) @(posedge Clk);
        #1;
        chk("sat_stall15", stall4, 15);
        chk("sat_occ", occ4, 1);
        rst4 = 1'b1;
        @(posedge Clk); #1;
        rst4 = 1'b0;
        chk("sat_rst_clear", stall4, 0);
        chk("sat_rst_valid", b4.out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline stage register with a ready/valid handshake and a 2-entry skid buffer. It replaces the plain enable/flush stage registers between pipeline stages, such as IF/ID and ID/EX. Downstream back-pressure stalls the stage without a combinational ready path, and a flush squashes every in-flight entry to a configurable NOP pattern. A saturating stall counter is kept for performance analysis.

## Interface
- WIDTH, 256, payload width in bits (MSB-first, bit 0 is the leftmost bit).
- NOP_VALUE, {WIDTH{1'b0}}, payload pattern held in empty or squashed entries.
- CNT_W, 32, width of the stall counter.

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Rst  in  1  reset; synchronous, active-high.
- flush  in  1  squash all entries; discards any handshake in the same cycle.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage can accept a payload; decoded from registered state only.
- in  in  [0:WIDTH-1]  upstream payload.
- out_valid  out  1  `out` holds a live payload.
- out_ready  in  1  downstream consumes `out`.
- out  out  [0:WIDTH-1]  payload; always driven directly from the main register.
- occupancy  out  2  number of live entries, 0..2.
- stall_cycles  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- Definitions:
  - accept = in_valid & in_ready & !flush.
  - emit = out_valid & out_ready & !flush.
- States:
  - EMPTY: occupancy 0.
  - ONE: occupancy 1, main register live.
  - FULL: occupancy 2, main and skid registers both live.
- Transitions:
  - EMPTY, accept: main <= in; go to ONE.
  - ONE, accept & emit: main <= in; stay in ONE.
  - ONE, accept only: skid <= in; go to FULL.
  - ONE, emit only: main <= NOP_VALUE; go to EMPTY.
  - FULL, emit: main <= skid; skid <= NOP_VALUE; go to ONE. No accept is possible, since in_ready=0.
  - All other cases: hold.
- Output decode:
  - in_ready = (state != FULL).
  - out_valid = (state != EMPTY).
  - occupancy follows the state.
- Priority: Rst > flush > normal operation.
- Flush: state <= EMPTY; main and skid <= NOP_VALUE. A handshake occurring in the flush cycle is dropped. Upstream must treat an accept in the flush cycle as squashed, which is consistent with pipeline-flush semantics.
- stall_cycles: increments by 1 in each cycle with out_valid & !out_ready, holds at 2^CNT_W-1, and is cleared only by Rst. Flush does not clear it. A flush cycle still counts if the stall condition holds.
- Ordering: payloads leave in strict arrival order, with no loss and no duplication outside flush.

## Timing
- Reset values: out_valid 0, in_ready 1, out = NOP_VALUE, occupancy 0, stall_cycles 0, skid = NOP_VALUE.
- Latency: a payload accepted at edge N appears on `out` with out_valid=1 after edge N.
- Throughput: 1 payload per cycle while out_ready=1.
- in_ready drops in the cycle after the edge that reaches FULL. in_ready and out_valid have no combinational path from in_valid, out_ready or flush.
- After flush at edge N: out_valid=0 and in_ready=1 from edge N onward, and out = NOP_VALUE.
- Reset asserted mid-transfer overrides everything; the pending payload is lost.

## Structure
- Shared package pipe_pkg holds:
  - state encoding: ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2; the value 2'd3 is illegal and recovers to EMPTY;
  - the default CNT_W constant.
- Sub-module pipe_data_reg (WIDTH, NOP_VALUE):
  - register with synchronous clear-to-NOP (Clk, Rst, clr, load, d, q);
  - instantiated twice, once for main and once for skid.
- The top level holds the state machine, the data-path muxing (in vs. skid into main) and the stall counter.

## Test plan
- Reset then stream: Rst for 2 cycles, then feed 0x1, 0x2, 0x3 with out_ready=1.
  - Expect out = 0x1, 0x2, 0x3 on consecutive cycles, each one cycle after its accept.
  - Expect occupancy to stay at 1 and stall_cycles=0.
- Back-pressure: out_ready=0 while feeding 0xA then 0xB.
  - Expect occupancy 2 and in_ready=0; 0xC is held upstream.
  - Raise out_ready: expect out = 0xA, 0xB, 0xC in order.
  - Expect stall_cycles to equal the number of stalled cycles.
- Flush while FULL: in FULL with in_valid=1 and in=0xD, assert flush for 1 cycle.
  - Next cycle expect out_valid=0, in_ready=1, out=NOP_VALUE, occupancy 0.
  - Expect 0xD never to appear on `out`.
- Simultaneous accept and emit in ONE: out_ready=1 and in_valid=1 every cycle for 100 cycles.
  - Expect in_ready to stay at 1 throughout and every payload to pass in order.
- Counter saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles.
  - Expect stall_cycles to stop at 15, and Rst to clear it to 0.
- Random ready/valid: random stimulus over 10k cycles with 5% random flush, checked against a scoreboard.
  - Expect no loss, duplication or reordering between flushes.
  - Expect occupancy never to exceed 2.
